br_update_ctrl: RTL and testbench

Scheduler for the branch predictor's single history-table update port. Sits between the reorder-buffer commit bus and `br_predictor`. Forwards resolved-branch outcomes as counter updates, buffering them in a small FIFO. Runs a table-clear sweep FSM on request, stalling updates while the sweep owns the port.

---
 rtl/br_update_ctrl.sv | 141 ++++++++++++++
 tb/tb_br_update_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/br_update_ctrl.sv
// br_update_ctrl
// Arbitrates the branch predictor's single history-table update port between
// committed-branch outcomes (buffered in a small FIFO) and a table-clear sweep.
//
// State table
//   state    | meaning
//   ST_IDLE  | forwarding outcomes: FIFO head first, else direct pass-through
//   ST_SWEEP | issuing clr commands for index 0..BHT_SIZE-1, outcomes queued
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rdy                        global ready; low freezes every register
//   *_from_rob_bus             committed-branch outcome and clear request
//   *_to_br_predictor          registered update / clear commands
//   busy                       high while sweeping (same cycles as clr_valid)
//   drop_cnt                   saturating count of dropped outcomes
//                              (exists only with BR_UPDATE_DROP_CNT_EN defined)
//
// Optional feature macro: BR_UPDATE_DROP_CNT_EN
module br_update_ctrl #(
    parameter int FIFO_DEPTH = 4,
    parameter int BHT_SIZE   = 256,
    parameter int BHT_ID_W   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                valid_from_rob_bus,
    input  logic [31:0]         pc_from_rob_bus,
    input  logic                is_taken_from_rob_bus,
    input  logic                clear_req_from_rob_bus,
    output logic                valid_to_br_predictor,
    output logic [31:0]         pc_to_br_predictor,
    output logic                is_taken_to_br_predictor,
    output logic                clr_valid_to_br_predictor,
    output logic [BHT_ID_W-1:0] clr_index_to_br_predictor,
    output logic                busy
`ifdef BR_UPDATE_DROP_CNT_EN
    ,
    output logic [15:0]         drop_cnt
`endif
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int PTR_W = AW + 1;

    typedef enum logic {ST_IDLE, ST_SWEEP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [32:0]        mem [FIFO_DEPTH];

    logic fifo_empty;
    logic fifo_full;
    logic sweep_last;
    logic do_issue;
    logic pop;
    logic direct;
    logic push;
`ifdef BR_UPDATE_DROP_CNT_EN
    logic drop;
`endif

    always_comb begin
        fifo_empty = (wr_ptr == rd_ptr);
        fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        sweep_last = (state == ST_SWEEP) &&
                     (clr_index_to_br_predictor == BHT_ID_W'(BHT_SIZE - 1));
        // The cycle that issues the last clear index also hands the port back
        // to updates, so the first queued outcome appears right after the sweep.
        do_issue   = !clear_req_from_rob_bus && ((state == ST_IDLE) || sweep_last);
        pop        = do_issue && !fifo_empty;
        direct     = do_issue && fifo_empty && valid_from_rob_bus;
        // A clear request discards the same-cycle outcome: it predates the clear.
        push       = valid_from_rob_bus && !clear_req_from_rob_bus && !direct &&
                     (!fifo_full || pop);
`ifdef BR_UPDATE_DROP_CNT_EN
        drop       = valid_from_rob_bus && !clear_req_from_rob_bus && !direct &&
                     fifo_full && !pop;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= ST_IDLE;
            wr_ptr                    <= '0;
            rd_ptr                    <= '0;
            valid_to_br_predictor     <= 1'b0;
            pc_to_br_predictor        <= '0;
            is_taken_to_br_predictor  <= 1'b0;
            clr_valid_to_br_predictor <= 1'b0;
            clr_index_to_br_predictor <= '0;
            busy                      <= 1'b0;
`ifdef BR_UPDATE_DROP_CNT_EN
            drop_cnt                  <= '0;
`endif
        end else if (rdy) begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= {is_taken_from_rob_bus, pc_from_rob_bus};
            end

            if (clear_req_from_rob_bus) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
            end

            valid_to_br_predictor <= pop || direct;
            if (pop) begin
                pc_to_br_predictor       <= mem[rd_ptr[AW-1:0]][31:0];
                is_taken_to_br_predictor <= mem[rd_ptr[AW-1:0]][32];
            end else if (direct) begin
                pc_to_br_predictor       <= pc_from_rob_bus;
                is_taken_to_br_predictor <= is_taken_from_rob_bus;
            end

            if (clear_req_from_rob_bus) begin
                state                     <= ST_SWEEP;
                clr_valid_to_br_predictor <= 1'b1;
                clr_index_to_br_predictor <= '0;
                busy                      <= 1'b1;
            end else if (sweep_last) begin
                state                     <= ST_IDLE;
                clr_valid_to_br_predictor <= 1'b0;
                busy                      <= 1'b0;
            end else if (state == ST_SWEEP) begin
                clr_index_to_br_predictor <= clr_index_to_br_predictor + 1'b1;
            end

`ifdef BR_UPDATE_DROP_CNT_EN
            if (drop && (drop_cnt != 16'hFFFF)) begin
                drop_cnt <= drop_cnt + 16'd1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_br_update_ctrl.sv
module tb_br_update_ctrl;

    localparam int DEPTH = 4;
    localparam int BHT   = 256;
    localparam int IDW   = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           rdy = 1'b1;
    logic           vin = 1'b0;
    logic [31:0]    pin = '0;
    logic           tin = 1'b0;
    logic           clr = 1'b0;
    logic           valid_o;
    logic [31:0]    pc_o;
    logic           taken_o;
    logic           clr_valid_o;
    logic [IDW-1:0] clr_index_o;
    logic           busy_o;
`ifdef BR_UPDATE_DROP_CNT_EN
    logic [15:0]    drop_cnt_o;
`endif

    br_update_ctrl #(.FIFO_DEPTH(DEPTH), .BHT_SIZE(BHT), .BHT_ID_W(IDW)) dut (
        .clk                       (clk),
        .rst                       (rst),
        .rdy                       (rdy),
        .valid_from_rob_bus        (vin),
        .pc_from_rob_bus           (pin),
        .is_taken_from_rob_bus     (tin),
        .clear_req_from_rob_bus    (clr),
        .valid_to_br_predictor     (valid_o),
        .pc_to_br_predictor        (pc_o),
        .is_taken_to_br_predictor  (taken_o),
        .clr_valid_to_br_predictor (clr_valid_o),
        .clr_index_to_br_predictor (clr_index_o),
        .busy                      (busy_o)
`ifdef BR_UPDATE_DROP_CNT_EN
        ,
        .drop_cnt                  (drop_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          at;
        bit          is_clr;
        logic [31:0] pc;
        bit          taken;
        int          idx;
    } exp_t;

    exp_t        exp_q[$];
    logic [32:0] mq[$];       // model outcome buffer: {taken, pc}
    bit          sweeping = 0;
    int          sweep_pos = 0;
    bit          m_uv = 0, m_cv = 0, m_t = 0;
    logic [31:0] m_pc = '0;
    int          m_idx = 0;
    int          drops = 0;

    // Behavioural model: outputs after each edge, expressed as transactions.
    always @(posedge clk) begin
        bit issue;
        logic [32:0] e;
        cyc++;
        if (rst) begin
            mq.delete();
            sweeping = 0; sweep_pos = 0;
            m_uv = 0; m_cv = 0; drops = 0;
        end else if (rdy) begin
            m_uv = 0; m_cv = 0;
            if (clr) begin
                mq.delete();
                sweeping = 1; sweep_pos = 0;
                m_cv = 1; m_idx = 0;
            end else begin
                issue = !sweeping || (sweep_pos == BHT - 1);
                if (sweeping && sweep_pos == BHT - 1) sweeping = 0;
                else if (sweeping) begin
                    sweep_pos++;
                    m_cv = 1; m_idx = sweep_pos;
                end
                if (issue) begin
                    if (mq.size() > 0) begin
                        e = mq.pop_front();
                        m_uv = 1; m_pc = e[31:0]; m_t = e[32];
                        if (vin) mq.push_back({tin, pin});
                    end else if (vin) begin
                        m_uv = 1; m_pc = pin; m_t = tin;
                    end
                end else if (vin) begin
                    if (mq.size() < DEPTH) mq.push_back({tin, pin});
                    else if (drops < 16'hFFFF) drops++;
                end
            end
        end
        if (m_uv) exp_q.push_back('{cyc, 1'b0, m_pc, m_t, 0});
        if (m_cv) exp_q.push_back('{cyc, 1'b1, 32'h0, 1'b0, m_idx});
    end

    // Monitor: pops the scoreboard whenever the DUT presents a command.
    always @(negedge clk) begin
        exp_t e;
        if (cyc >= 1) begin
            while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
                e = exp_q.pop_front();
                checks++; errors++;
                $display("FAIL missing_cmd cyc=%0d expected clr=%0d pc=%h idx=%0d due at %0d", cyc, e.is_clr, e.pc, e.idx, e.at);
            end
            checks++;
            if (busy_o !== clr_valid_o) begin
                errors++;
                $display("FAIL busy_vs_clr cyc=%0d busy=%b required=%b", cyc, busy_o, clr_valid_o);
            end
`ifdef BR_UPDATE_DROP_CNT_EN
            checks++;
            if (drop_cnt_o !== 16'(drops)) begin
                errors++;
                $display("FAIL drop_cnt cyc=%0d got=%0d required=%0d", cyc, drop_cnt_o, drops);
            end
`endif
            if (valid_o === 1'b1 || clr_valid_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].at != cyc) begin
                    errors++;
                    $display("FAIL unexpected_cmd cyc=%0d valid=%b pc=%h clr_valid=%b idx=%0d", cyc, valid_o, pc_o, clr_valid_o, clr_index_o);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_clr) begin
                        if (clr_valid_o !== 1'b1 || valid_o !== 1'b0 || clr_index_o !== IDW'(e.idx)) begin
                            errors++;
                            $display("FAIL clr_cmd cyc=%0d got clr_valid=%b valid=%b idx=%0d required idx=%0d", cyc, clr_valid_o, valid_o, clr_index_o, e.idx);
                        end
                    end else begin
                        if (valid_o !== 1'b1 || clr_valid_o !== 1'b0 || pc_o !== e.pc || taken_o !== e.taken) begin
                            errors++;
                            $display("FAIL upd_cmd cyc=%0d got valid=%b clr=%b pc=%h t=%b required pc=%h t=%b", cyc, valid_o, clr_valid_o, pc_o, taken_o, e.pc, e.taken);
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [31:0] p, input bit t, input bit c, input bit r);
        vin = v; pin = p; tin = t; clr = c; rdy = r;
        @(posedge clk); #1;
        vin = 0; clr = 0; rdy = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 32'h0, 0, 0, 1);
    endtask

    initial begin
        rst = 1;
        repeat (3) @(posedge clk);
        #1 rst = 0;
        @(negedge clk);
        checks++;
        if (valid_o !== 0 || pc_o !== 0 || taken_o !== 0 || clr_valid_o !== 0 || clr_index_o !== 0 || busy_o !== 0) begin
            errors++;
            $display("FAIL reset_state valid=%b pc=%h t=%b clr=%b idx=%0d busy=%b required all 0", valid_o, pc_o, taken_o, clr_valid_o, clr_index_o, busy_o);
        end
        @(posedge clk); #1;

        drive(1, 32'h1000, 1, 0, 1);              // single direct update
        idle(4);

        drive(0, 32'h0, 0, 1, 1);                 // full sweep
        idle(BHT + 4);

        drive(0, 32'h0, 0, 1, 1);                 // 6 outcomes during sweep, 2 dropped
        for (int i = 0; i < 6; i++) drive(1, 32'h10 + 32'(4 * i), i[0], 0, 1);
        idle(BHT + 8);

        drive(0, 32'h0, 0, 1, 1);                 // 3 queued, then flushed by clear
        for (int i = 0; i < 3; i++) drive(1, 32'h200 + 32'(4 * i), 1, 0, 1);
        drive(1, 32'h2FC, 1, 1, 1);
        idle(BHT + 4);

        drive(0, 32'h0, 0, 1, 1);                 // restart mid-sweep
        idle(99);
        drive(0, 32'h0, 0, 1, 1);
        idle(BHT + 4);

        drive(0, 32'h0, 0, 1, 1);                 // rdy low at index 40
        idle(40);
        for (int i = 0; i < 3; i++) drive(1, 32'hDEAD0000, 1, 1, 0);
        idle(BHT);

        drive(1, 32'h3000, 0, 0, 1);              // reset mid-sweep
        drive(0, 32'h0, 0, 1, 1);
        idle(20);
        rst = 1; drive(1, 32'h4000, 1, 0, 1); rst = 0;
        drive(1, 32'h5000, 1, 0, 1);
        idle(4);

        for (int i = 0; i < 5000; i++) begin
            rst = ($urandom_range(0, 2999) == 0);
            drive($urandom_range(0, 1) == 1, $urandom, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 399) == 0, $urandom_range(0, 9) != 0);
            rst = 0;
        end
        idle(BHT + 10);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
